readout_sequencer: RTL and testbench
====================================

# readout_sequencer

Initiator side of the interpreter's `iEn`/`oIntRdy` readout protocol. It buffers incoming reservoir state vectors in a small FIFO and issues them one at a time to the interpreter. It holds each vector stable for the whole job, captures the interpreter result, and presents it on a valid/ready output port. It sits between the reservoir update logic and the interpreter, and adds timeout supervision because the interpreter has no reset.

## Interface
Parameters:
- `data_width`, 3, bits per reservoir neuron value
- `reservoir_size`, 4, neurons per state vector
- `weight_size`, 16, interpreter weight width (used only to size the result)
- `layer`, 1, interpreter layer parameter (used only to size the result)
- `fifo_depth`, 4, input FIFO entries; power of two, ≥2
- `timeout_cycles`, 64, maximum cycles allowed for one interpreter job; ≥8

Derived widths:
- VEC_W = reservoir_size*data_width
- RES_W = (data_width+weight_size+layer)*2+1

Ports:
- `iClk` in 1: the single clock; all logic on posedge
- `iRst_n` in 1: asynchronous, active-low reset
- `iValid` in 1: upstream vector valid
- `oReady` out 1: FIFO can accept; equals !full
- `iData` in VEC_W: upstream reservoir state vector
- `oIntEn` out 1: start pulse to interpreter
- `oIntData` out VEC_W: vector driven to interpreter
- `iIntValue` in RES_W: interpreter result
- `iIntRdy` in 1: interpreter result ready
- `oValid` out 1: result register full
- `iReady` in 1: downstream accepts result
- `oValue` out RES_W: captured result
- `oTimeout` out 1: sticky job-timeout flag
- `oBusy` out 1: high in ISSUE, BUSY and DRAIN

## Operation
- **Reset values:** `oIntEn`=0, `oIntData`=0, `oValid`=0, `oValue`=0, `oTimeout`=0, `oBusy`=0, `oReady`=1. Reset also empties the FIFO, clears the counter and sets the state to FLUSH.
- **FIFO:**
  - Push on `iValid && oReady`.
  - Pop only on the IDLE→ISSUE transition.
  - Pointers carry one extra wrap bit; full = pointers equal except the MSB.
  - A push is allowed on the same edge as a pop while not full. When full, `oReady`=0 and no push occurs even if a pop happens that edge.
- **States:** FLUSH, IDLE, ISSUE, BUSY, DRAIN.
  - **FLUSH:** the counter increments each cycle and restarts at 0 whenever `iIntRdy`=1. Exit to IDLE when the counter reaches timeout_cycles-1. This lets an interpreter job in flight across reset finish and be discarded.
  - **IDLE:** when FIFO non-empty && !`oValid` && !`iIntRdy`, load `oIntData` from the FIFO head, pop, set `oIntEn`=1 and go to ISSUE.
  - **ISSUE:** one cycle. `oIntEn` clears at the exit edge; clear the counter; go to BUSY.
  - **BUSY:**
    - If `iIntRdy`=1: capture `iIntValue` into `oValue`, set `oValid`=1, go to DRAIN.
    - Else, if the counter equals timeout_cycles-1: set `oTimeout`=1, discard the job and go to FLUSH.
    - Otherwise increment the counter.
    - `iIntRdy` has priority over timeout on the same edge.
  - **DRAIN:** wait for `iIntRdy`=0, then go to IDLE. Additional result cycles are ignored; `oValue` is captured once per job.
- `oIntData` stays stable from the ISSUE edge until the next ISSUE.
- **Output handshake:**
  - `oValid` clears on an edge with `oValid && iReady`.
  - `oValue` holds its value until the next capture.
  - While `oValid`=1 no new job is issued, so a result is never overwritten.
- `oTimeout` is cleared only by `iRst_n`.

## Timing
- **Issue latency:** with FIFO empty, state IDLE, `oValid`=0 and `iIntRdy`=0, a vector accepted at edge N produces `oIntEn`=1 and valid `oIntData` after edge N+1. `oIntEn` is high for exactly one cycle.
- **Capture latency:** `oValid` rises on the first edge at which `iIntRdy`=1 is sampled in BUSY.
- **Back-to-back:** the next `oIntEn` comes no earlier than two edges after `iIntRdy` is sampled low. That is: DRAIN→IDLE on one edge, IDLE→ISSUE on the next, and only if the result has been consumed.
- **Throughput:** at most one job in flight.
- **Asynchronous reset mid-job:** outputs return to their reset values immediately. The interpreter's late `iIntRdy` is absorbed in FLUSH.

## Test plan
1. **Reset and single job.** Release `iRst_n`; hold `iIntRdy`=0 for 64 cycles, so the block reaches IDLE. Push `iData`=12'hA53. Required: `oIntEn` pulses one cycle with `oIntData`=12'hA53. The model asserts `iIntRdy` 10 cycles later with `iIntValue`=41'h1_2345_6789A. Required: `oValid`=1 and `oValue`=41'h1_2345_6789A on that edge.
2. **Backpressure.** With `iReady`=0, push 5 vectors: 0x001, 0x002, 0x003, 0x004, 0x005.
   - Required: only one job is issued, and 0x002–0x005 fill the FIFO.
   - `oReady`=0 with 4 entries in the FIFO; a sixth push is refused.
   - Raise `iReady`: results appear in order 1..5, each with a distinct `oIntData`.
3. **Timeout.** The model never asserts `iIntRdy`. Required: `oTimeout`=1 on the 64th BUSY edge after the ISSUE exit, then FLUSH. `oValid` stays 0, and `oTimeout` remains set through later successful jobs.
4. **Simultaneous events.** Case A: `iIntRdy` rises on the same edge the counter hits 63 → result captured, `oTimeout` stays 0. Case B: push and pop on the same edge with 2 entries → count stays 2.
5. **Reset mid-job.** Drop `iRst_n` while in BUSY. Required: all outputs return to their reset values asynchronously and the FIFO is empty. After release, the model's late `iIntRdy` pulse is ignored (`oValid`=0), and the next job issues only after 64 quiet cycles.
6. **Lingering ready.** Model holds `iIntRdy`=1 for 3 cycles. Required: one capture only, and no `oIntEn` until 2 edges after `iIntRdy` falls.

Source files
------------

// File: rtl/readout_sequencer.sv
// readout_sequencer: buffers reservoir vectors and issues them one at a time
// to the interpreter, captures results and supervises each job with a timeout.
module readout_sequencer #(
    parameter int data_width     = 3,
    parameter int reservoir_size = 4,
    parameter int weight_size    = 16,
    parameter int layer          = 1,
    parameter int fifo_depth     = 4,
    parameter int timeout_cycles = 64,
    localparam int VEC_W = reservoir_size * data_width,
    localparam int RES_W = (data_width + weight_size + layer) * 2 + 1
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [VEC_W-1:0] iData,
    output logic             oIntEn,
    output logic [VEC_W-1:0] oIntData,
    input  logic [RES_W-1:0] iIntValue,
    input  logic             iIntRdy,
    output logic             oValid,
    input  logic             iReady,
    output logic [RES_W-1:0] oValue,
    output logic             oTimeout,
    output logic             oBusy
);

    localparam int AW = $clog2(fifo_depth);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(timeout_cycles);

    localparam logic [CW-1:0] CNT_MAX = CW'(timeout_cycles - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    localparam logic [2:0] FLUSH = 3'd0;
    localparam logic [2:0] IDLE  = 3'd1;
    localparam logic [2:0] ISSUE = 3'd2;
    localparam logic [2:0] BUSY  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    logic [VEC_W-1:0] mem_q [fifo_depth];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             int_en_q, int_en_d;
    logic [VEC_W-1:0] int_data_q, int_data_d;
    logic             valid_q, valid_d;
    logic [RES_W-1:0] value_q, value_d;
    logic             timeout_q, timeout_d;

    logic full;
    logic empty;
    logic push;

    // Extra wrap bit distinguishes full from empty when indices match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = iValid && !full;

    always_ff @(posedge iClk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= iData;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        int_en_d   = int_en_q;
        int_data_d = int_data_q;
        valid_d    = valid_q;
        value_d    = value_q;
        timeout_d  = timeout_q;

        if (valid_q && iReady) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            FLUSH: begin
                // Let a job left running across reset or timeout finish.
                if (iIntRdy) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE: begin
                if (!empty && !valid_q && !iIntRdy) begin
                    int_data_d = mem_q[rd_ptr_q[AW-1:0]];
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    int_en_d   = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                int_en_d = 1'b0;
                cnt_d    = '0;
                state_d  = BUSY;
            end
            BUSY: begin
                if (iIntRdy) begin
                    value_d = iIntValue;
                    valid_d = 1'b1;
                    state_d = DRAIN;
                end else if (cnt_q == CNT_MAX) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = FLUSH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DRAIN: begin
                if (!iIntRdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = FLUSH;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= FLUSH;
            cnt_q      <= '0;
            int_en_q   <= 1'b0;
            int_data_q <= '0;
            valid_q    <= 1'b0;
            value_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            int_en_q   <= int_en_d;
            int_data_q <= int_data_d;
            valid_q    <= valid_d;
            value_q    <= value_d;
            timeout_q  <= timeout_d;
        end
    end

    assign oReady   = !full;
    assign oIntEn   = int_en_q;
    assign oIntData = int_data_q;
    assign oValid   = valid_q;
    assign oValue   = value_q;
    assign oTimeout = timeout_q;
    assign oBusy    = (state_q == ISSUE) || (state_q == BUSY) ||
                      (state_q == DRAIN);

endmodule

// File: tb/tb_readout_sequencer.sv
// tb_readout_sequencer: randomized and directed stimulus against a
// transaction-level model of the readout sequencer.
module tb_readout_sequencer;

    localparam int DW    = 3;
    localparam int RS    = 4;
    localparam int WS    = 16;
    localparam int LY    = 1;
    localparam int FD    = 4;
    localparam int TO    = 64;
    localparam int VEC_W = RS * DW;
    localparam int RES_W = (DW + WS + LY) * 2 + 1;

    logic             iClk = 1'b0;
    logic             iRst_n;
    logic             iValid;
    logic             oReady;
    logic [VEC_W-1:0] iData;
    logic             oIntEn;
    logic [VEC_W-1:0] oIntData;
    logic [RES_W-1:0] iIntValue;
    logic             iIntRdy;
    logic             oValid;
    logic             iReady;
    logic [RES_W-1:0] oValue;
    logic             oTimeout;
    logic             oBusy;

    readout_sequencer #(
        .data_width    (DW),
        .reservoir_size(RS),
        .weight_size   (WS),
        .layer         (LY),
        .fifo_depth    (FD),
        .timeout_cycles(TO)
    ) dut (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iValid   (iValid),
        .oReady   (oReady),
        .iData    (iData),
        .oIntEn   (oIntEn),
        .oIntData (oIntData),
        .iIntValue(iIntValue),
        .iIntRdy  (iIntRdy),
        .oValid   (oValid),
        .iReady   (iReady),
        .oValue   (oValue),
        .oTimeout (oTimeout),
        .oBusy    (oBusy)
    );

    always #5 iClk = ~iClk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_res  = 0;

    // Interpreter stand-in controls
    logic             rsp_en    = 1'b1;
    int               rsp_delay = 4;
    int               rsp_hold  = 1;
    logic             use_fixed = 1'b0;
    logic [RES_W-1:0] fixed_val = '0;

    // Reference model state
    logic [VEC_W-1:0] pushq[$];
    logic [RES_W-1:0] resq[$];
    logic             inflight   = 1'b0;
    logic             flush_pend = 1'b1;
    logic             exp_to     = 1'b0;
    logic [RES_W-1:0] job_val    = '0;
    int               job_d      = 0;
    int               age        = 0;
    int               gap        = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RES_W-1:0] interp(input logic [VEC_W-1:0] x);
        return {x[4:0], ~x, x, ~x};
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return oValid;
            1:       return oIntEn;
            default: return oTimeout;
        endcase
    endfunction

    task automatic tick();
        @(negedge iClk);
        #1;
    endtask

    task automatic wait_for(input string tag, input int sel, input int maxc);
        int n = 0;
        while (sig(sel) == 1'b0 && n < maxc) begin
            tick();
            n++;
        end
        check(tag, 64'(sig(sel)), 64'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        iValid = 1'b0;
        iReady = 1'b1;
        while ((pushq.size() != 0 || resq.size() != 0 || inflight ||
                iIntRdy) && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 64'(n < 3000), 64'd1);
        repeat (3) tick();
    endtask

    task automatic push1(input logic [VEC_W-1:0] d);
        iValid = 1'b1;
        iData  = d;
        tick();
        iValid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " oIntEn"}, 64'(oIntEn), 64'd0);
        check({tag, " oIntData"}, 64'(oIntData), 64'd0);
        check({tag, " oValid"}, 64'(oValid), 64'd0);
        check({tag, " oValue"}, 64'(oValue), 64'd0);
        check({tag, " oTimeout"}, 64'(oTimeout), 64'd0);
        check({tag, " oBusy"}, 64'(oBusy), 64'd0);
        check({tag, " oReady"}, 64'(oReady), 64'd1);
    endtask

    // Interpreter: answers each start pulse after rsp_delay cycles and
    // holds ready for rsp_hold cycles with a value that changes per cycle.
    initial begin
        int               d;
        int               h;
        logic [RES_W-1:0] v;
        iIntRdy   = 1'b0;
        iIntValue = '0;
        forever begin
            @(negedge iClk);
            if (iRst_n === 1'b1 && oIntEn && rsp_en) begin
                d = rsp_delay;
                h = rsp_hold;
                v = use_fixed ? fixed_val : interp(oIntData);
                repeat (d) @(negedge iClk);
                for (int k = 0; k < h; k++) begin
                    #1;
                    iIntRdy   = 1'b1;
                    iIntValue = v + RES_W'(k);
                    @(negedge iClk);
                end
                #1;
                iIntRdy   = 1'b0;
                iIntValue = '0;
            end
        end
    end

    // Transaction monitor: inputs seen at a negedge were applied at the
    // preceding posedge, so handshakes are resolved against prior outputs.
    initial begin
        logic             p_ready;
        logic             p_valid;
        logic             p_to;
        logic             p_en;
        logic [RES_W-1:0] p_value;
        logic [VEC_W-1:0] dv;
        p_ready = 1'b1;
        p_valid = 1'b0;
        p_to    = 1'b0;
        p_en    = 1'b0;
        p_value = '0;
        forever begin
            @(negedge iClk);
            if (iRst_n !== 1'b1) begin
                pushq.delete();
                resq.delete();
                inflight   = 1'b0;
                flush_pend = 1'b1;
                gap        = 0;
            end else begin
                if (iIntRdy) gap = 0;
                else if (gap < 100000) gap++;
                if (iValid && p_ready) pushq.push_back(iData);
                if (p_valid && iReady) begin
                    check("result pending", 64'(resq.size() > 0), 64'd1);
                    if (resq.size() > 0)
                        check("result value", 64'(p_value),
                              64'(resq.pop_front()));
                    n_res++;
                end
                if (inflight && !oIntEn) age++;
                if (oValid && !p_valid) begin
                    check("capture in flight", 64'(inflight), 64'd1);
                    check("capture not timeout", 64'(exp_to), 64'd0);
                    check("capture value", 64'(oValue), 64'(job_val));
                    check("capture latency", 64'(age), 64'(job_d + 1));
                    resq.push_back(job_val);
                    inflight = 1'b0;
                end
                if (oTimeout && !p_to) begin
                    check("timeout expected", 64'(inflight && exp_to), 64'd1);
                    check("timeout latency", 64'(age), 64'(TO + 1));
                    inflight   = 1'b0;
                    flush_pend = 1'b1;
                    gap        = 0;
                end
                if (oIntEn) begin
                    check("issue pulse width", 64'(p_en), 64'd0);
                    check("issue spacing",
                          64'(gap >= (flush_pend ? TO + 1 : 2)), 64'd1);
                    check("issue single job", 64'(inflight), 64'd0);
                    check("issue has entry", 64'(pushq.size() > 0), 64'd1);
                    flush_pend = 1'b0;
                    if (pushq.size() > 0) begin
                        dv = pushq.pop_front();
                        check("issue data", 64'(oIntData), 64'(dv));
                        inflight = 1'b1;
                        age      = 0;
                        exp_to   = !rsp_en;
                        job_d    = rsp_delay;
                        job_val  = use_fixed ? fixed_val : interp(dv);
                    end
                end
            end
            p_ready = oReady;
            p_valid = oValid;
            p_to    = oTimeout;
            p_en    = oIntEn;
            p_value = oValue;
        end
    end

    initial begin
        int res0;
        iRst_n = 1'b0;
        iValid = 1'b0;
        iData  = '0;
        iReady = 1'b1;
        repeat (3) tick();
        check_reset("por");
        @(negedge iClk);
        #2 iRst_n = 1'b1;

        // Single job with fixed result and exact issue latency
        repeat (70) tick();
        check("flushed idle", 64'(oBusy), 64'd0);
        rsp_delay = 10;
        rsp_hold  = 1;
        use_fixed = 1'b1;
        fixed_val = 41'h1_2345_6789A;
        push1(12'hA53);
        check("t1 no early issue", 64'(oIntEn), 64'd0);
        tick();
        check("t1 issue", 64'(oIntEn), 64'd1);
        check("t1 data", 64'(oIntData), 64'hA53);
        tick();
        check("t1 pulse end", 64'(oIntEn), 64'd0);
        check("t1 busy", 64'(oBusy), 64'd1);
        wait_for("t1 capture", 0, 40);
        check("t1 value", 64'(oValue), 64'h1_2345_6789A);
        use_fixed = 1'b0;
        drain("t1 drain");

        // Ready on the very edge the counter reaches its limit
        rsp_delay = TO;
        push1(12'h3C7);
        drain("t4a drain");
        check("t4a no timeout", 64'(oTimeout), 64'd0);

        // Lingering ready
        rsp_delay = 5;
        rsp_hold  = 3;
        push1(12'h111);
        push1(12'h222);
        drain("t6 drain");

        // Backpressure
        rsp_delay = 4;
        rsp_hold  = 1;
        iReady    = 1'b0;
        res0      = n_res;
        for (int i = 1; i <= 5; i++) begin
            iValid = 1'b1;
            iData  = VEC_W'(i);
            tick();
        end
        iValid = 1'b0;
        check("t2 full", 64'(oReady), 64'd0);
        iValid = 1'b1;
        iData  = 12'h006;
        tick();
        iValid = 1'b0;
        repeat (20) tick();
        check("t2 still full", 64'(oReady), 64'd0);
        check("t2 result held", 64'(oValid), 64'd1);
        drain("t2 drain");
        check("t2 result count", 64'(n_res - res0), 64'd5);

        // Push and pop on the same edge with two entries queued
        iReady = 1'b0;
        push1(12'h0A0);
        wait_for("t4b first capture", 0, 40);
        repeat (4) tick();
        iValid = 1'b1;
        iData  = 12'h0B1;
        tick();
        iData  = 12'h0B2;
        tick();
        iValid = 1'b0;
        repeat (2) tick();
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        iValid = 1'b1;
        iData  = 12'h0B3;
        check("t4b result taken", 64'(oValid), 64'd0);
        tick();
        iValid = 1'b0;
        check("t4b issue", 64'(oIntEn), 64'd1);
        check("t4b issue data", 64'(oIntData), 64'h0B1);
        check("t4b ready", 64'(oReady), 64'd1);
        wait_for("t4b second capture", 0, 40);
        tick();
        iValid = 1'b1;
        iData  = 12'h0B4;
        tick();
        check("t4b three entries", 64'(oReady), 64'd1);
        iData = 12'h0B5;
        tick();
        iValid = 1'b0;
        check("t4b four entries", 64'(oReady), 64'd0);
        drain("t4b drain");

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            iValid    = ($urandom % 2) == 0;
            iData     = VEC_W'($urandom);
            iReady    = ($urandom % 4) != 0;
            rsp_delay = $urandom_range(1, 20);
            rsp_hold  = $urandom_range(1, 3);
            tick();
        end
        drain("rand drain");

        // Timeout
        rsp_en = 1'b0;
        push1(12'h5E5);
        wait_for("t3 timeout", 2, 200);
        tick();
        check("t3 no result", 64'(oValid), 64'd0);
        check("t3 flush", 64'(oBusy), 64'd0);
        rsp_en    = 1'b1;
        rsp_delay = 3;
        push1(12'h6E6);
        drain("t3 drain");
        check("t3 sticky", 64'(oTimeout), 64'd1);

        // Reset while busy
        rsp_delay = 30;
        rsp_hold  = 2;
        push1(12'h7A1);
        wait_for("t5 issue", 1, 20);
        push1(12'h7A2);
        repeat (5) tick();
        check("t5 busy", 64'(oBusy), 64'd1);
        @(negedge iClk);
        #2 iRst_n = 1'b0;
        #1;
        check_reset("t5 async");
        @(negedge iClk);
        #2 iRst_n = 1'b1;
        tick();
        rsp_delay = 3;
        rsp_hold  = 1;
        push1(12'h7A3);
        wait_for("t5 reissue", 1, 200);
        check("t5 reissue data", 64'(oIntData), 64'h7A3);
        check("t5 late ready ignored", 64'(oValid), 64'd0);
        drain("t5 drain");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
